// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared sample widths, types and helpers for the IIR filter chain
package iir_pkg;

   // Filter output sample width (two's complement)
   localparam int DW         = 4;
   // Default log2 of the decimation factor
   localparam int LOG2_D_DEF = 2;
   // Largest supported log2 decimation; sets the width of the sign-extend helper
   localparam int LOG2_D_MAX = 4;
   localparam int SEXT_W     = DW + LOG2_D_MAX;

   typedef logic signed [DW-1:0] sample_t;

   // Accumulator-side block state; IDLE means no sample of the current block seen yet
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_e;

   // Sign-extend a sample to the widest accumulator; callers truncate to their own width
   function automatic logic signed [SEXT_W-1:0] sext(input sample_t x);
      return {{LOG2_D_MAX{x[DW-1]}}, x};
   endfunction

endpackage

// File: rtl/iir_sat_cnt.sv
// rtl/iir_sat_cnt.sv - saturating event counter
module iir_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // Count events, holding at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/iir_decimator.sv
// rtl/iir_decimator.sv - block-sum/mean decimator behind the IIR filter, drop-on-stall output
module iir_decimator
   import iir_pkg::*;
#(
   parameter int  LOG2_D = LOG2_D_DEF,
   parameter int  CNTW   = 8,
   localparam int ACCW   = DW + LOG2_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] out_sum,
   output logic [DW-1:0]   out_mean,
   output logic            drop,
   output logic [CNTW-1:0] drop_cnt
);

   localparam logic [LOG2_D-1:0] CNT_LAST = '1;

   acc_state_e             state_q;
   logic signed [ACCW-1:0] acc_q;
   logic [LOG2_D-1:0]      cnt_q;

   logic                   out_valid_q;
   logic signed [ACCW-1:0] out_sum_q;
   logic signed [DW-1:0]   out_mean_q;
   logic                   drop_q;

   logic signed [ACCW-1:0] sample_ext;
   logic signed [ACCW-1:0] acc_base;
   logic signed [ACCW-1:0] block_sum_d;
   logic signed [DW-1:0]   mean_d;
   logic                   accept;
   logic                   last;
   logic                   load_d;
   logic                   drop_d;

   // Running sum, block completion and output-slot decisions
   always_comb begin
      sample_ext  = ACCW'(sext(sample_t'(in_data)));
      // A fresh block always starts from zero, whatever acc_q holds
      acc_base    = (state_q == ST_IDLE) ? '0 : acc_q;
      block_sum_d = acc_base + sample_ext;
      mean_d      = DW'(block_sum_d >>> LOG2_D);
      accept      = in_valid && !clr;
      last        = accept && (cnt_q == CNT_LAST);
      load_d      = last && (!out_valid_q || out_ready);
      drop_d      = last && out_valid_q && !out_ready;
   end

   // Accumulator FSM: gather DECIM accepted samples, restart on clr or block end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (clr || last) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         state_q <= ST_ACC;
         acc_q   <= block_sum_d;
         cnt_q   <= cnt_q + LOG2_D'(1);
      end
   end

   // One-entry output slot: reload on completion if free or being drained, else hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_mean_q  <= '0;
      end else if (load_d) begin
         out_valid_q <= 1'b1;
         out_sum_q   <= block_sum_d;
         out_mean_q  <= mean_d;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Sticky flag recording that at least one completed block was lost
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_q <= 1'b0;
      end else if (drop_d) begin
         drop_q <= 1'b1;
      end
   end

   iir_sat_cnt #(
      .W (CNTW)
   ) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc_i (drop_d),
      .cnt_o (drop_cnt)
   );

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_mean  = out_mean_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_iir_decimator.sv
// tb/tb_iir_decimator.sv - self-checking bench for iir_decimator against a block-level model
module tb_iir_decimator;
   import iir_pkg::*;

   localparam int LD   = 2;
   localparam int DEC  = 1 << LD;
   localparam int ACCW = DW + LD;
   localparam int CNTW = 8;
   localparam int CMAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            clr = 1'b0;
   logic            in_valid = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            out_ready = 1'b1;
   logic            out_valid;
   logic [ACCW-1:0] out_sum;
   logic [DW-1:0]   out_mean;
   logic            drop;
   logic [CNTW-1:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: pending samples of the open block plus the output slot
   int q[$];
   int m_valid = 0;
   int m_sum   = 0;
   int m_mean  = 0;
   int m_drop  = 0;
   int m_cnt   = 0;

   iir_decimator #(
      .LOG2_D (LD),
      .CNTW   (CNTW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_mean  (out_mean),
      .drop      (drop),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic int floor_div(input int s);
      if (s >= 0) return s / DEC;
      return -((-s + DEC - 1) / DEC);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_valid"}, int'(out_valid), m_valid);
      check({tag, "_sum"}, int'($signed(out_sum)), m_sum);
      check({tag, "_mean"}, int'($signed(out_mean)), m_mean);
      check({tag, "_drop"}, int'(drop), m_drop);
      check({tag, "_dropcnt"}, int'(drop_cnt), m_cnt);
   endtask

   task automatic model_reset();
      q.delete();
      m_valid = 0;
      m_sum   = 0;
      m_mean  = 0;
      m_drop  = 0;
      m_cnt   = 0;
   endtask

   // Drive one cycle from a negedge, advance the model at the posedge, check after it
   task automatic step(input string tag, input int v, input int d, input int c, input int r);
      logic [31:0] dv;
      int          fin;
      int          s;
      dv        = d;
      in_valid  = v[0];
      in_data   = dv[DW-1:0];
      clr       = c[0];
      out_ready = r[0];
      @(posedge clk);
      fin = 0;
      s   = 0;
      if (c != 0) begin
         q.delete();
      end else if (v != 0) begin
         q.push_back(d);
         if (q.size() == DEC) begin
            foreach (q[i]) s += q[i];
            q.delete();
            fin = 1;
         end
      end
      if (fin != 0) begin
         if (m_valid == 0 || r != 0) begin
            m_valid = 1;
            m_sum   = s;
            m_mean  = floor_div(s);
         end else begin
            m_drop = 1;
            if (m_cnt < CMAX) m_cnt++;
         end
      end else if (m_valid != 0 && r != 0) begin
         m_valid = 0;
      end
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int d;
      model_reset();
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b1;

      // 1: four ones -> sum 4, mean 1
      for (int i = 0; i < 4; i++) step("t1", 1, 1, 0, 1);
      check("t1_lit_sum", int'($signed(out_sum)), 4);
      check("t1_lit_mean", int'($signed(out_mean)), 1);

      // 2: extremes and floor rounding
      for (int i = 0; i < 4; i++) step("t2a", 1, -8, 0, 1);
      check("t2a_lit_sum", int'($signed(out_sum)), -32);
      check("t2a_lit_mean", int'($signed(out_mean)), -8);
      step("t2b", 1, 7, 0, 1);
      step("t2b", 1, 7, 0, 1);
      step("t2b", 1, 7, 0, 1);
      step("t2b", 1, -8, 0, 1);
      check("t2b_lit_sum", int'($signed(out_sum)), 13);
      check("t2b_lit_mean", int'($signed(out_mean)), 3);
      step("t2c", 1, -1, 0, 1);
      for (int i = 0; i < 3; i++) step("t2c", 1, 0, 0, 1);
      check("t2c_lit_mean", int'($signed(out_mean)), -1);
      step("t2flush", 0, 0, 0, 1);

      // 3: stalled consumer, second block dropped, then one handshake
      for (int i = 0; i < 8; i++) step("t3", 1, 2, 0, 0);
      check("t3_lit_sum", int'($signed(out_sum)), 8);
      check("t3_lit_drop", int'(drop), 1);
      check("t3_lit_cnt", int'(drop_cnt), 1);
      step("t3hs", 0, 0, 0, 1);
      check("t3_lit_valid", int'(out_valid), 0);

      // 4: reset mid-block discards the partial sum
      step("t4", 1, 3, 0, 1);
      step("t4", 1, 3, 0, 1);
      pulse_reset();
      for (int i = 0; i < 4; i++) step("t4b", 1, 1, 0, 1);
      check("t4_lit_sum", int'($signed(out_sum)), 4);

      // 5: valid gaps, then clr colliding with a sample
      for (int i = 0; i < 4; i++) begin
         step("t5gap", 1, 5, 0, 1);
         step("t5gap", 0, 0, 0, 1);
      end
      check("t5_lit_sum", int'($signed(out_sum)), 20);
      step("t5clr", 1, 1, 0, 1);
      step("t5clr", 1, 2, 0, 1);
      step("t5clr", 1, 7, 1, 1);
      for (int i = 0; i < 4; i++) step("t5clr", 1, 1, 0, 1);
      check("t5_lit_clr", int'($signed(out_sum)), 4);

      // 6: continuous samples, ready asserted only on completion cycles
      for (int i = 0; i < 64; i++) begin
         d = int'($urandom_range(0, 15)) - 8;
         step("t6bb", 1, d, 0, ((i % DEC) == DEC - 1) ? 1 : 0);
      end
      check("t6_lit_nodrop", int'(drop), 0);

      // Randomized mix of gaps, clr and backpressure
      for (int i = 0; i < 400; i++) begin
         d = int'($urandom_range(0, 15)) - 8;
         step("rnd", ($urandom_range(0, 3) != 0) ? 1 : 0, d,
              ($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, 1)));
      end

      // Drop counter saturation under a permanently stalled consumer
      step("satflush", 0, 0, 0, 1);
      for (int i = 0; i < DEC * 301; i++) step("sat", 1, i % 8, 0, 0);
      check("sat_lit_cnt", int'(drop_cnt), CMAX);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
